// File: rtl/req_ack_pkg.sv
// Shared types and helpers for the multi-channel req/ack arbiter.
// Optional build macro: REQ_ACK_ARB_SVA_EN (embedded assertions, see req_ack_arb.sv).
package req_ack_pkg;

    // Service engine states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } req_ack_state_e;

    // Smallest legal configuration.
    localparam int NCH_MIN = 2;
    localparam int LAT_MIN = 1;

    // Wrap-around increment of a channel pointer in the range 0..n-1.
    function automatic int rr_next(input int ptr, input int n);
        if (ptr + 1 >= n) begin
            return 0;
        end
        return ptr + 1;
    endfunction

endpackage

// File: rtl/req_ack_rr_pick.sv
// Combinational round-robin picker: returns the first set pend bit at or
// after rr_ptr, wrapping from NCH-1 back to 0.
module req_ack_rr_pick
    import req_ack_pkg::*;
#(
    parameter  int NCH  = 4,
    localparam int ID_W = $clog2(NCH)
) (
    input  logic [NCH-1:0]  pend,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [ID_W-1:0] sel_id,
    output logic            sel_vld
);

    // w_rot[k] is the pend bit k positions after rr_ptr; w_idx[k] its channel.
    logic [NCH-1:0]  w_rot;
    logic [ID_W-1:0] w_idx [NCH];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_rot
            assign w_idx[gi] = ID_W'((int'(rr_ptr) + gi) % NCH);
            assign w_rot[gi] = pend[w_idx[gi]];
        end
    endgenerate

    // Priority encode the rotated vector; the smallest offset from rr_ptr wins.
    always_comb begin
        sel_vld = 1'b0;
        sel_id  = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                sel_vld = 1'b1;
                sel_id  = w_idx[k];
            end
        end
    end

endmodule

// File: rtl/req_ack_arb.sv
// Multi-channel req/ack responder. Each channel's level req is latched as
// pending; one shared engine grants pending channels round-robin and returns
// a one-cycle ack pulse LAT cycles after the grant.
// Optional build macro: REQ_ACK_ARB_SVA_EN adds embedded concurrent
// assertions and covers; behaviour is identical either way.
module req_ack_arb
    import req_ack_pkg::*;
#(
    parameter  int NCH  = 4,
    parameter  int LAT  = 1,
    localparam int ID_W = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  req,
    output logic [NCH-1:0]  ack,
    output logic            busy,
    output logic [ID_W-1:0] grant_id
);

    localparam int CNT_W = $clog2(LAT + 1);

    // Reject configurations the engine cannot represent.
    generate
        if (NCH < NCH_MIN || LAT < LAT_MIN) begin : g_param_err
            $error("req_ack_arb: NCH must be >= 2 and LAT must be >= 1");
        end
    endgenerate

    req_ack_state_e   r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [ID_W-1:0]  r_id;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [NCH-1:0]   r_pend;
    logic [NCH-1:0]   r_ack;
    logic             r_busy;

    logic [ID_W-1:0]  w_sel_id;
    logic             w_sel_vld;
    logic [NCH-1:0]   w_ack_fire;
    logic [NCH-1:0]   w_pend_next;

    // Per-channel pending logic. w_ack_fire marks the edge on which the ack
    // register is loaded for a channel: that edge clears its pend and also
    // ignores its req, so a held req re-pends one cycle later and ack pulses
    // can never merge back-to-back on the same channel.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign w_ack_fire[gi]  = (r_state == ACK) && (r_id == ID_W'(gi));
            assign w_pend_next[gi] = w_ack_fire[gi] ? 1'b0 : (r_pend[gi] | req[gi]);
        end
    endgenerate

    // Round-robin choice among currently pending channels.
    req_ack_rr_pick #(
        .NCH (NCH)
    ) u_rr_pick (
        .pend    (r_pend),
        .rr_ptr  (r_rr_ptr),
        .sel_id  (w_sel_id),
        .sel_vld (w_sel_vld)
    );

    // Pending register: sticky until its channel is acked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    // Service engine: grant in IDLE, count LAT-1 cycles in WAIT, fire ack in ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_id     <= '0;
            r_rr_ptr <= '0;
            r_ack    <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_sel_vld) begin
                        r_id   <= w_sel_id;
                        r_busy <= 1'b1;
                        if (LAT == 1) begin
                            r_state <= ACK;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_W'(LAT - 1);
                        end
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    // Ack pulse appears in the cycle after this edge; the
                    // pointer moves past the served channel for fairness.
                    r_ack    <= w_ack_fire;
                    r_rr_ptr <= ID_W'(rr_next(int'(r_id), NCH));
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign busy     = r_busy;
    assign grant_id = r_id;

`ifdef REQ_ACK_ARB_SVA_EN
    // At most one channel acked in any cycle.
    a_ack_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(ack));

    // Busy and the idle state are mutually exclusive.
    a_busy_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !(busy && (r_state == IDLE)));

    // All NCH channels requesting together.
    c_all_req: cover property (@(posedge clk) disable iff (!rst_n)
        (req == {NCH{1'b1}}));

    generate
        for (gi = 0; gi < NCH; gi++) begin : g_sva
            // Ack is a single-cycle pulse.
            a_ack_pulse: assert property (@(posedge clk) disable iff (!rst_n)
                ack[gi] |=> !ack[gi]);

            // An ack only follows a pending request (pend clears on the
            // loading edge, so look one cycle back).
            a_ack_pend: assert property (@(posedge clk) disable iff (!rst_n)
                ack[gi] |-> $past(r_pend[gi]));

            // Every pending channel is eventually served.
            a_pend_live: assert property (@(posedge clk) disable iff (!rst_n)
                r_pend[gi] |-> s_eventually ack[gi]);

            // Each channel gets acked at least once.
            c_ack: cover property (@(posedge clk) disable iff (!rst_n)
                ack[gi]);
        end
    endgenerate
`endif

endmodule

// File: tb/tb_req_ack_arb.sv
// Self-checking bench for req_ack_arb: one instance with LAT=1 and one with
// LAT=3 (both NCH=4). Expected acks (channel, cycle) are queued when stimulus
// is driven and matched by a monitor when acks appear.
module tb_req_ack_arb;

    logic       clk;
    logic       rst_n;
    logic [3:0] req1, req3;
    logic [3:0] ack1, ack3;
    logic       busy1, busy3;
    logic [1:0] gid1, gid3;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    req_ack_arb #(.NCH(4), .LAT(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req1),
        .ack      (ack1),
        .busy     (busy1),
        .grant_id (gid1)
    );

    req_ack_arb #(.NCH(4), .LAT(3)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req3),
        .ack      (ack3),
        .busy     (busy3),
        .grant_id (gid3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc == k after posedge k; the monitor and stimulus run on negedges.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Scoreboard monitors: an ack (or an expected ack) at this cycle is compared.
    always @(negedge clk) begin
        logic [31:0] e1;
        logic [31:0] e3;
        e1 = 0;
        e3 = 0;
        if (q1.size() > 0 && q1[0].cyc == cyc) e1 = 32'd1 << q1[0].ch;
        if (q3.size() > 0 && q3[0].cyc == cyc) e3 = 32'd1 << q3[0].ch;
        if (ack1 != 4'd0 || e1 != 0) begin
            $display("txn dut=lat1 cyc=%0d ack=%b exp=%b", cyc, ack1, e1[3:0]);
            check("ack_lat1", {28'd0, ack1}, e1);
            if (e1 != 0) void'(q1.pop_front());
        end
        if (ack3 != 4'd0 || e3 != 0) begin
            $display("txn dut=lat3 cyc=%0d ack=%b exp=%b", cyc, ack3, e3[3:0]);
            check("ack_lat3", {28'd0, ack3}, e3);
            if (e3 != 0) void'(q3.pop_front());
        end
    end

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Safety net: the directed sequence is bounded, this only guards a hang.
    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        req1  = 4'd0;
        req3  = 4'd0;
        tick(2);
        check("rst_ack1",  {28'd0, ack1},  0);
        check("rst_busy1", {31'd0, busy1}, 0);
        check("rst_gid1",  {30'd0, gid1},  0);
        check("rst_ack3",  {28'd0, ack3},  0);
        check("rst_busy3", {31'd0, busy3}, 0);
        check("rst_gid3",  {30'd0, gid3},  0);
        rst_n = 1'b1;
        tick(3);

        // Single req on channel 2, LAT=1: ack two edges after sampling.
        n = cyc + 1;
        req1 = 4'b0100;
        q1.push_back('{ch: 2, cyc: n + 2});
        tick(1);
        req1 = 4'd0;
        check("t1_busy_pre", {31'd0, busy1}, 0);
        tick(1);
        check("t1_busy", {31'd0, busy1}, 1);
        check("t1_gid",  {30'd0, gid1},  2);
        tick(1);
        check("t1_busy_post", {31'd0, busy1}, 0);
        tick(3);

        // All four channels at once, LAT=3: rr order 0..3, 4 cycles apart.
        n = cyc + 1;
        req3 = 4'b1111;
        for (int k = 0; k < 4; k++) q3.push_back('{ch: k, cyc: n + 4 + 4 * k});
        tick(1);
        req3 = 4'd0;
        tick(18);

        // Serve ch1 so rr_ptr becomes 2, then pend 0011 must give ch0 before ch1.
        n = cyc + 1;
        req1 = 4'b0010;
        q1.push_back('{ch: 1, cyc: n + 2});
        tick(1);
        req1 = 4'd0;
        tick(4);
        n = cyc + 1;
        req1 = 4'b0011;
        q1.push_back('{ch: 0, cyc: n + 2});
        q1.push_back('{ch: 1, cyc: n + 4});
        tick(1);
        req1 = 4'd0;
        tick(6);

        // rr_ptr is 2 again: pend 1001 gives ch3 then wraps to ch0.
        n = cyc + 1;
        req1 = 4'b1001;
        q1.push_back('{ch: 3, cyc: n + 2});
        q1.push_back('{ch: 0, cyc: n + 4});
        tick(1);
        req1 = 4'd0;
        tick(6);

        // req[1] held for 20 sampling edges: ack every 3 cycles.
        n = cyc + 1;
        req1 = 4'b0010;
        for (int k = 0; 3 * k <= 19; k++) q1.push_back('{ch: 1, cyc: n + 3 * k + 2});
        tick(20);
        req1 = 4'd0;
        tick(6);

        // Reset while the LAT=3 engine waits on ch3: no stale ack afterwards.
        n = cyc + 1;
        req3 = 4'b1000;
        tick(1);
        req3 = 4'd0;
        tick(1);
        check("t5_busy_wait", {31'd0, busy3}, 1);
        check("t5_gid_wait",  {30'd0, gid3},  3);
        tick(1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_ack3",  {28'd0, ack3},  0);
        check("t5_rst_busy3", {31'd0, busy3}, 0);
        check("t5_rst_gid3",  {30'd0, gid3},  0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        check("t5_busy_after", {31'd0, busy3}, 0);
        tick(8);
        check("t5_busy_late", {31'd0, busy3}, 0);

        check("drain_q1", q1.size(), 0);
        check("drain_q3", q3.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
